// File: rtl/oled_pkg.sv
// Shared constants, SSD1306 init list and FSM types for the OLED command sequencer.
package oled_pkg;

    localparam logic [7:0] OLED_I2C_ADDR = 8'h78;
    localparam logic [7:0] OLED_CTRL_CMD = 8'h00;
    localparam logic [7:0] OLED_CTRL_DAT = 8'h40;

    localparam int INIT_LEN = 15;
    localparam int IDX_W    = 4;

    // Packed so that element 0, the first byte sent, sits in the low bits.
    localparam logic [INIT_LEN-1:0][7:0] INIT_LIST = {
        8'hAF, 8'h14, 8'h8D, 8'h7F, 8'h81, 8'hC8, 8'hA1, 8'h40,
        8'h00, 8'hD3, 8'h3F, 8'hA8, 8'h00, 8'h20, 8'hAE
    };

    typedef enum logic [2:0] {
        PWRUP,
        ISSUE,
        WAIT,
        GAP,
        IDLE
    } seq_state_t;

    typedef enum logic {
        SRC_INIT,
        SRC_FIFO
    } seq_src_t;

    function automatic logic [7:0] init_byte(input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < INIT_LEN; i++) begin
            if (idx == IDX_W'(i)) begin
                b = INIT_LIST[i];
            end
        end
        return b;
    endfunction

    function automatic logic [7:0] ctrl_byte(input logic is_data);
        return is_data ? OLED_CTRL_DAT : OLED_CTRL_CMD;
    endfunction

endpackage

// File: rtl/oled_sync_fifo.sv
// Synchronous FIFO with a fall-through head; reset empties it by clearing the pointers.
module oled_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/oled_cmd_sequencer.sv
// Feeds the I2C master one {control, payload} pair at a time: power-up wait,
// SSD1306 init list, then the software-filled command/data queue.
module oled_cmd_sequencer
    import oled_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int POWERUP_CYC = 20000,
    parameter int TIMEOUT_CYC = 65535,
    parameter int GAP_CYC     = 4
) (
    input  logic                           apb_pclk,
    input  logic                           apb_prstn,
    input  logic                           wr_valid,
    input  logic                           wr_is_data,
    input  logic [7:0]                     wr_byte,
    output logic                           wr_ready,
    input  logic                           clr_sticky,
    output logic                           i2c_start,
    output logic [7:0]                     i2c_ctrl,
    output logic [7:0]                     i2c_data,
    input  logic                           i2c_done,
    output logic                           init_done,
    output logic                           busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           overflow,
    output logic                           timeout_err
);

    localparam int CNT_W = 32;

    seq_state_t       state;
    seq_state_t       state_nx;
    seq_src_t         src;
    seq_src_t         src_nx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] cnt_inc;
    logic             start_nx;
    logic [7:0]       ctrl_nx;
    logic [7:0]       data_nx;
    logic             init_done_nx;
    logic             timeout_set;
    logic             overflow_set;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [8:0]       fifo_head;

    oled_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk   (apb_pclk),
        .rst_n (apb_prstn),
        .push  (wr_valid),
        .pop   (fifo_pop),
        .din   ({wr_is_data, wr_byte}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wr_ready     = !fifo_full;
    assign busy         = (state != IDLE);
    assign cnt_inc      = cnt + 1'b1;
    assign overflow_set = wr_valid && fifo_full && !fifo_pop;

    always_comb begin
        state_nx     = state;
        src_nx       = src;
        idx_nx       = idx;
        cnt_nx       = cnt;
        start_nx     = i2c_start;
        ctrl_nx      = i2c_ctrl;
        data_nx      = i2c_data;
        init_done_nx = init_done;
        timeout_set  = 1'b0;
        fifo_pop     = 1'b0;

        case (state)
            PWRUP: begin
                if (cnt_inc >= CNT_W'(POWERUP_CYC)) begin
                    state_nx = ISSUE;
                    src_nx   = SRC_INIT;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end

            ISSUE: begin
                start_nx = 1'b1;
                cnt_nx   = CNT_W'(1);
                state_nx = WAIT;
                if (src == SRC_INIT) begin
                    ctrl_nx = OLED_CTRL_CMD;
                    data_nx = init_byte(idx);
                end else begin
                    ctrl_nx  = ctrl_byte(fifo_head[8]);
                    data_nx  = fifo_head[7:0];
                    fifo_pop = 1'b1;
                end
            end

            // A timed-out entry is dropped, never retried.
            WAIT: begin
                if (i2c_done) begin
                    start_nx = 1'b0;
                    cnt_nx   = '0;
                    state_nx = GAP;
                end else if (cnt >= CNT_W'(TIMEOUT_CYC)) begin
                    timeout_set = 1'b1;
                    start_nx    = 1'b0;
                    cnt_nx      = '0;
                    state_nx    = GAP;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end

            GAP: begin
                if (cnt_inc >= CNT_W'(GAP_CYC)) begin
                    cnt_nx = '0;
                    if (src == SRC_FIFO) begin
                        state_nx = IDLE;
                    end else if (idx == IDX_W'(INIT_LEN - 1)) begin
                        init_done_nx = 1'b1;
                        state_nx     = IDLE;
                    end else begin
                        idx_nx   = idx + 1'b1;
                        state_nx = ISSUE;
                    end
                end else begin
                    cnt_nx = cnt_inc;
                end
            end

            IDLE: begin
                if (init_done && !fifo_empty) begin
                    src_nx   = SRC_FIFO;
                    state_nx = ISSUE;
                end
            end

            default: begin
                state_nx = PWRUP;
                cnt_nx   = '0;
            end
        endcase
    end

    // Sticky flags: a new event in the same cycle as clr_sticky wins.
    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            state       <= PWRUP;
            src         <= SRC_INIT;
            idx         <= '0;
            cnt         <= '0;
            i2c_start   <= 1'b0;
            i2c_ctrl    <= 8'h00;
            i2c_data    <= 8'h00;
            init_done   <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            src         <= src_nx;
            idx         <= idx_nx;
            cnt         <= cnt_nx;
            i2c_start   <= start_nx;
            i2c_ctrl    <= ctrl_nx;
            i2c_data    <= data_nx;
            init_done   <= init_done_nx;
            overflow    <= overflow_set | (overflow & ~clr_sticky);
            timeout_err <= timeout_set | (timeout_err & ~clr_sticky);
        end
    end

endmodule

// File: tb/tb_oled_cmd_sequencer.sv
// Directed bench for oled_cmd_sequencer: init replay, queue traffic, overflow,
// timeout, stray done pulses and mid-transaction reset.
module tb_oled_cmd_sequencer;

    localparam int FIFO_DEPTH  = 16;
    localparam int POWERUP_CYC = 10;
    localparam int TIMEOUT_CYC = 50;
    localparam int GAP_CYC     = 4;
    localparam int CW          = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_is_data = 1'b0;
    logic [7:0]    wr_byte = 8'h00;
    logic          clr_sticky = 1'b0;
    logic          i2c_done;
    logic          resp_done = 1'b0;
    logic          extra_done = 1'b0;
    logic          auto_done = 1'b1;

    logic          wr_ready;
    logic          i2c_start;
    logic [7:0]    i2c_ctrl;
    logic [7:0]    i2c_data;
    logic          init_done;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          timeout_err;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            unstable = 0;
    int            done_timer = 0;
    logic          start_q = 1'b0;
    logic [15:0]   log_q [$];
    int            rise_q [$];
    int            base;
    int            hi;
    int            lo;
    int            k;

    logic [7:0] init_exp [15] = '{8'hAE, 8'h20, 8'h00, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                  8'hA1, 8'hC8, 8'h81, 8'h7F, 8'h8D, 8'h14, 8'hAF};

    assign i2c_done = resp_done | extra_done;

    always #5 clk = ~clk;

    oled_cmd_sequencer #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .POWERUP_CYC (POWERUP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .GAP_CYC     (GAP_CYC)
    ) dut (
        .apb_pclk    (clk),
        .apb_prstn   (rst_n),
        .wr_valid    (wr_valid),
        .wr_is_data  (wr_is_data),
        .wr_byte     (wr_byte),
        .wr_ready    (wr_ready),
        .clr_sticky  (clr_sticky),
        .i2c_start   (i2c_start),
        .i2c_ctrl    (i2c_ctrl),
        .i2c_data    (i2c_data),
        .i2c_done    (i2c_done),
        .init_done   (init_done),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    // I2C master stand-in: logs each start rise and answers with done five cycles later.
    always @(posedge clk) begin
        #1;
        cyc++;
        resp_done = 1'b0;
        if (!rst_n) begin
            done_timer = 0;
        end else if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) resp_done = 1'b1;
        end
        if (i2c_start && !start_q) begin
            log_q.push_back({i2c_ctrl, i2c_data});
            rise_q.push_back(cyc);
            if (auto_done) done_timer = 5;
        end else if (i2c_start && start_q && ({i2c_ctrl, i2c_data} !== log_q[$])) begin
            unstable++;
        end
        start_q = i2c_start;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic d, input logic [7:0] b, input logic clr);
        wr_valid   = v;
        wr_is_data = d;
        wr_byte    = b;
        clr_sticky = clr;
        @(negedge clk);
        wr_valid   = 1'b0;
        wr_is_data = 1'b0;
        wr_byte    = 8'h00;
        clr_sticky = 1'b0;
    endtask

    task automatic waitLog(input int target, input int budget);
        int n = 0;
        while (log_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_log_size", log_q.size(), target);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_idle_busy", busy, 0);
    endtask

    task automatic countLow(input int already, output int total);
        total = already;
        while (i2c_start !== 1'b1 && total < 200) begin
            @(negedge clk);
            if (i2c_start !== 1'b1) total++;
        end
    endtask

    initial begin
        $display("[TB] start");

        // Reset values, then 17 pushes during init into a 16-deep queue.
        repeat (3) @(negedge clk);
        checkOutput("rst_start", i2c_start, 0);
        checkOutput("rst_ctrl", i2c_ctrl, 8'h00);
        checkOutput("rst_data", i2c_data, 8'h00);
        checkOutput("rst_init_done", init_done, 0);
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_fifo_count", fifo_count, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);
        checkOutput("rst_wr_ready", wr_ready, 1);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, (i % 2 == 1), 8'(8'h10 + i), 1'b0);
        end
        checkOutput("ovf_count_full", fifo_count, 16);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_wr_ready", wr_ready, 0);
        checkOutput("ovf_init_pending", init_done, 0);
        applyStimulus(1'b1, 1'b0, 8'hEE, 1'b1);
        checkOutput("ovf_set_wins_clr", overflow, 1);
        checkOutput("ovf_count_unchanged", fifo_count, 16);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("ovf_cleared", overflow, 0);

        waitLog(31, 2000);
        waitIdle(200);
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("init_tx_%0d", i), log_q[i], {8'h00, init_exp[i]});
        end
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("fifo_tx_%0d", i), log_q[15 + i],
                        {((i % 2 == 1) ? 8'h40 : 8'h00), 8'(8'h10 + i)});
        end
        // Init pitch: 6 start-high + 4 gap + 1 issue; queue pitch adds one IDLE cycle.
        checkOutput("init_pitch", rise_q[1] - rise_q[0], 11);
        checkOutput("init_to_fifo_pitch", rise_q[15] - rise_q[14], 12);
        checkOutput("fifo_pitch", rise_q[16] - rise_q[15], 12);
        checkOutput("post_init_done", init_done, 1);
        checkOutput("post_init_count", fifo_count, 0);
        checkOutput("post_init_wr_ready", wr_ready, 1);

        // Two pushes from IDLE: start rises two cycles after the first push.
        base = log_q.size();
        wr_valid = 1'b1; wr_is_data = 1'b1; wr_byte = 8'h55;
        @(negedge clk);
        checkOutput("lat_count_1", fifo_count, 1);
        checkOutput("lat_start_lo_1", i2c_start, 0);
        wr_is_data = 1'b0; wr_byte = 8'hA5;
        @(negedge clk);
        checkOutput("lat_count_2", fifo_count, 2);
        checkOutput("lat_start_lo_2", i2c_start, 0);
        wr_valid = 1'b0; wr_byte = 8'h00;
        @(negedge clk);
        checkOutput("lat_start_hi", i2c_start, 1);
        checkOutput("lat_count_pop", fifo_count, 1);
        checkOutput("lat_ctrl", i2c_ctrl, 8'h40);
        checkOutput("lat_data", i2c_data, 8'h55);
        waitLog(base + 2, 100);
        waitIdle(200);
        checkOutput("pair_tx_0", log_q[base], 16'h4055);
        checkOutput("pair_tx_1", log_q[base + 1], 16'h00A5);
        checkOutput("pair_count_0", fifo_count, 0);

        // Withheld done: timeout after TIMEOUT_CYC high cycles, next entry still goes.
        base = log_q.size();
        auto_done = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h11, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h22, 1'b0);
        k = 0;
        while (i2c_start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        checkOutput("to_start_seen", i2c_start, 1);
        hi = 0;
        while (i2c_start === 1'b1 && hi < 200) begin hi++; @(negedge clk); end
        auto_done = 1'b1;
        checkOutput("to_high_cycles", hi, TIMEOUT_CYC);
        checkOutput("to_flag", timeout_err, 1);
        countLow(1, lo);
        checkOutput("to_gap_low", lo, GAP_CYC + 2);
        waitIdle(200);
        checkOutput("to_tx_0", log_q[base], 16'h0011);
        checkOutput("to_tx_1", log_q[base + 1], 16'h0022);
        checkOutput("to_flag_sticky", timeout_err, 1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("to_flag_cleared", timeout_err, 0);

        // Stray done pulses in IDLE and in GAP.
        base = log_q.size();
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_done_busy", busy, 0);
        checkOutput("idle_done_no_tx", log_q.size(), base);
        checkOutput("idle_done_count", fifo_count, 0);
        applyStimulus(1'b1, 1'b1, 8'h33, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h44, 1'b0);
        k = 0;
        while (i2c_start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        k = 0;
        while (i2c_start === 1'b1 && k < 50) begin @(negedge clk); k++; end
        checkOutput("gap_done_fell", i2c_start, 0);
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        checkOutput("gap_done_no_pop", fifo_count, 1);
        countLow(2, lo);
        checkOutput("gap_done_low", lo, GAP_CYC + 2);
        waitIdle(200);
        checkOutput("gap_tx_0", log_q[base], 16'h4033);
        checkOutput("gap_tx_1", log_q[base + 1], 16'h4044);

        // Reset while waiting on init entry 7 with two entries queued.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = log_q.size();
        applyStimulus(1'b1, 1'b0, 8'hC1, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hC2, 1'b0);
        waitLog(base + 8, 400);
        checkOutput("mid_idx7_tx", log_q[base + 7], {8'h00, init_exp[7]});
        checkOutput("mid_in_wait", i2c_start, 1);
        checkOutput("mid_queued", fifo_count, 2);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_async_start", i2c_start, 0);
        checkOutput("mid_async_count", fifo_count, 0);
        checkOutput("mid_async_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        base = log_q.size();
        waitLog(base + 15, 400);
        waitIdle(200);
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("replay_tx_%0d", i), log_q[base + i], {8'h00, init_exp[i]});
        end
        repeat (5) @(negedge clk);
        checkOutput("replay_no_fifo_tx", log_q.size(), base + 15);
        checkOutput("replay_count", fifo_count, 0);
        checkOutput("replay_init_done", init_done, 1);
        checkOutput("ctrl_data_stable", unstable, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
